// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: loads PC-1(key) on start, then emits K1..K16 (or K16..K1) over valid/ready.
// First subkey is valid one cycle after an accepted start; subkey_ready low freezes all state.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        start,
  output logic        busy,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        done
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  // Table entries use FIPS 1-based bit numbering (bit 1 is the MSB).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1_perm(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1[i])];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[6'(47 - i)] = cd[6'(56 - PC2[i])];
    end
    return r;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] v, input logic right, input logic two);
    logic [27:0] r;
    case ({right, two})
      2'b00:   r = {v[26:0], v[27]};
      2'b01:   r = {v[25:0], v[27:26]};
      2'b10:   r = {v[0], v[27:1]};
      default: r = {v[1:0], v[27:2]};
    endcase
    return r;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [27:0] r_c, r_d, w_c_nxt, w_d_nxt;
  logic [3:0]  r_round, w_round_nxt;
  logic        r_decrypt, w_decrypt_nxt;
  logic        r_done, w_done_nxt;
  logic [55:0] w_pc1;
  logic        w_shift2;

  assign w_pc1 = pc1_perm(key_in);
  // Single-position steps fall on transitions into rounds 2, 9 and 16 in either direction.
  assign w_shift2 = !((r_round == 4'd0) || (r_round == 4'd7) || (r_round == 4'd14));

  always_comb begin
    w_state_nxt   = r_state;
    w_c_nxt       = r_c;
    w_d_nxt       = r_d;
    w_round_nxt   = r_round;
    w_decrypt_nxt = r_decrypt;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_ACTIVE;
          w_decrypt_nxt = decrypt;
          w_round_nxt   = 4'd0;
          if (decrypt) begin
            w_c_nxt = w_pc1[55:28];
            w_d_nxt = w_pc1[27:0];
          end else begin
            w_c_nxt = rot28(w_pc1[55:28], 1'b0, 1'b0);
            w_d_nxt = rot28(w_pc1[27:0], 1'b0, 1'b0);
          end
        end
      end
      S_ACTIVE: begin
        if (subkey_ready) begin
          if (r_round == 4'd15) begin
            w_state_nxt = S_IDLE;
            w_round_nxt = 4'd0;
            w_done_nxt  = 1'b1;
          end else begin
            w_round_nxt = r_round + 4'd1;
            w_c_nxt     = rot28(r_c, r_decrypt, w_shift2);
            w_d_nxt     = rot28(r_d, r_decrypt, w_shift2);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_c       <= '0;
      r_d       <= '0;
      r_round   <= '0;
      r_decrypt <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_c       <= w_c_nxt;
      r_d       <= w_d_nxt;
      r_round   <= w_round_nxt;
      r_decrypt <= w_decrypt_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign busy         = (r_state == S_ACTIVE);
  assign subkey_valid = (r_state == S_ACTIVE);
  assign round_idx    = r_round;
  assign done         = r_done;
  assign subkey       = pc2_perm({r_c, r_d});

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: vector table plus hand-built stall, ignored-start, back-to-back and reset sequences.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] key_in;
  logic        decrypt;
  logic        start;
  logic        busy;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic        done;

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .start        (start),
    .busy         (busy),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .done         (done)
  );

  typedef struct packed {
    logic [47:0] key;
    logic [3:0]  idx;
  } exp_t;

  typedef struct packed {
    logic [63:0]  key;
    logic         dec;
    logic [767:0] exp;
  } vec_t;

  localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;

  exp_t        sb[$];
  vec_t        vecs[6];
  logic [47:0] ks[16];
  logic [767:0] enc_exp, dec_exp, zero_exp, ones_exp;
  int          n_tests  = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic        rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) subkey_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic launch(input string name, input logic [63:0] k, input logic d, input logic [767:0] e);
    for (int i = 0; i < 16; i++) sb.push_back('{key: e[i*48 +: 48], idx: 4'(i)});
    key_in  = k;
    decrypt = d;
    start   = 1'b1;
    step();
    start   = 1'b0;
    key_in  = ~k;
    decrypt = ~d;
    check({name, "_first_valid"}, 64'(subkey_valid), 64'd1);
    check({name, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string name, input int base, input logic [47:0] hold, input int n_done);
    int c;
    c = 0;
    while ((sb.size() != 0 || busy) && c < 400) begin
      step();
      c++;
    end
    check({name, "_in_budget"}, 64'(c < 400), 64'd1);
    check({name, "_done_pulse"}, 64'(done), 64'd1);
    check({name, "_valid_low"}, 64'(subkey_valid), 64'd0);
    check({name, "_idx_zero"}, 64'(round_idx), 64'd0);
    check({name, "_cd_kept"}, 64'(subkey), 64'(hold));
    step();
    check({name, "_done_one_cycle"}, 64'(done), 64'd0);
    step();
    check({name, "_done_count"}, 64'(done_cnt - base), 64'(n_done));
  endtask

  // Scoreboard monitor: pops on every handshake and checks stalled outputs hold.
  initial begin
    logic        p_stall;
    logic [47:0] p_key;
    logic [3:0]  p_idx;
    exp_t        e;
    p_stall = 1'b0;
    p_key   = '0;
    p_idx   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_stall = 1'b0;
      end else begin
        if (p_stall) begin
          check("stall_subkey", 64'(subkey), 64'(p_key));
          check("stall_idx", 64'(round_idx), 64'(p_idx));
        end
        if (done) done_cnt++;
        if (subkey_valid && subkey_ready) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_handshake: subkey 0x%0h idx %0d, scoreboard empty", subkey, round_idx);
          end else begin
            e = sb.pop_front();
            check("subkey", 64'(subkey), 64'(e.key));
            check("round_idx", 64'(round_idx), 64'(e.idx));
          end
        end
        p_stall = subkey_valid && !subkey_ready;
        p_key   = subkey;
        p_idx   = round_idx;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c;
    logic [47:0] hk;

    ks = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
           48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
           48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
           48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    zero_exp = '0;
    ones_exp = '1;
    for (int i = 0; i < 16; i++) begin
      enc_exp[i*48 +: 48] = ks[i];
      dec_exp[i*48 +: 48] = ks[15-i];
    end
    vecs[0] = '{key: KEY_STD, dec: 1'b0, exp: enc_exp};
    vecs[1] = '{key: KEY_STD, dec: 1'b1, exp: dec_exp};
    vecs[2] = '{key: 64'h0, dec: 1'b0, exp: zero_exp};
    vecs[3] = '{key: 64'hFFFFFFFFFFFFFFFF, dec: 1'b0, exp: ones_exp};
    vecs[4] = '{key: KEY_STD ^ 64'h0101010101010101, dec: 1'b0, exp: enc_exp};
    vecs[5] = '{key: 64'hFFFFFFFFFFFFFFFF, dec: 1'b1, exp: ones_exp};

    rst_n = 1'b0;
    start = 1'b0;
    decrypt = 1'b0;
    key_in = '0;
    subkey_ready = 1'b1;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(subkey_valid), 64'd0);
    check("rst_idx", 64'(round_idx), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_subkey", 64'(subkey), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      base = done_cnt;
      launch($sformatf("vec%0d", v), vecs[v].key, vecs[v].dec, vecs[v].exp);
      wait_done($sformatf("vec%0d", v), base, vecs[v].exp[15*48 +: 48], 1);
      step();
    end

    // Back-pressure: random ready with a forced 5-cycle stall at round 3.
    rand_rdy = 1'b1;
    base = done_cnt;
    launch("bp", KEY_STD, 1'b0, enc_exp);
    c = 0;
    while (round_idx != 4'd3 && c < 200) begin
      step();
      c++;
    end
    check("bp_reach_idx3", 64'(round_idx), 64'd3);
    rand_rdy = 1'b0;
    subkey_ready = 1'b0;
    hk = subkey;
    for (int s = 0; s < 5; s++) step();
    check("bp_hold_key", 64'(subkey), 64'(hk));
    check("bp_hold_idx", 64'(round_idx), 64'd3);
    check("bp_hold_busy", 64'(busy), 64'd1);
    rand_rdy = 1'b1;
    wait_done("bp", base, ks[15], 1);
    rand_rdy = 1'b0;
    subkey_ready = 1'b1;
    step();

    // Start pulse mid-sequence must be ignored.
    base = done_cnt;
    launch("ign", KEY_STD, 1'b0, enc_exp);
    c = 0;
    while (round_idx != 4'd7 && c < 100) begin
      step();
      c++;
    end
    key_in = 64'hFEDCBA9876543210;
    decrypt = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("ign_busy", 64'(busy), 64'd1);
    wait_done("ign", base, ks[15], 1);

    // Start accepted in the same cycle as done.
    base = done_cnt;
    launch("b2b_a", KEY_STD, 1'b0, enc_exp);
    c = 0;
    while (!done && c < 100) begin
      step();
      c++;
    end
    check("b2b_done_seen", 64'(done), 64'd1);
    launch("b2b_b", KEY_STD, 1'b1, dec_exp);
    wait_done("b2b", base, ks[0], 2);

    // Asynchronous reset mid-sequence.
    launch("rst", KEY_STD, 1'b0, enc_exp);
    c = 0;
    while (round_idx != 4'd10 && c < 100) begin
      step();
      c++;
    end
    check("rst_reach_idx10", 64'(round_idx), 64'd10);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_valid", 64'(subkey_valid), 64'd0);
    check("arst_idx", 64'(round_idx), 64'd0);
    check("arst_subkey", 64'(subkey), 64'd0);
    sb.delete();
    base = done_cnt;
    step();
    step();
    check("arst_no_done", 64'(done_cnt - base), 64'd0);
    rst_n = 1'b1;
    step();
    base = done_cnt;
    launch("post_rst", KEY_STD, 1'b0, enc_exp);
    wait_done("post_rst", base, ks[15], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
